// File: rtl/fb_writer.sv
// fb_writer: write-side port into the 512x512 RGB555 frame buffer SRAM.
//
// A start-coordinate command sets the X/Y write pointer. Pixels are buffered
// in a small FIFO. Each pixel is then written as two byte strobes, low byte
// first, and the pointer advances in raster order after the high byte.
// With BLANK_ONLY set, a strobe is only issued when video_fetch was low on
// the edge that registers it, so scanout fetches are never disturbed.
//
// Ports
//   clk          system clock, posedge
//   rst          asynchronous active-high reset
//   cmd_valid/cmd_ready/cmd_x/cmd_y   start-coordinate command handshake
//   px_valid/px_ready/px_data         pixel stream handshake (16-bit)
//   video_fetch  scanout owns SRAM this cycle
//   wstb         one-cycle byte-write strobe
//   waddr        byte address {Y, X, byte_sel}
//   srpage       SRAM page {3'b000, Y[8:4]}
//   wdata        byte to write, valid with wstb
//   busy         FIFO non-empty or write in progress
//
// State   | meaning
// S_IDLE  | nothing in flight; pops the FIFO head when one is available
// S_LO    | pixel register loaded, low byte pending
// S_HI    | low byte written, high byte pending

module fb_writer #(
    parameter int FIFO_DEPTH = 16,
    parameter bit BLANK_ONLY = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [8:0]  cmd_x,
    input  logic [8:0]  cmd_y,
    input  logic        px_valid,
    output logic        px_ready,
    input  logic [15:0] px_data,
    input  logic        video_fetch,
    output logic        wstb,
    output logic [18:0] waddr,
    output logic [7:0]  srpage,
    output logic [7:0]  wdata,
    output logic        busy
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [15:0] mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic [AW:0] fill;
    logic        empty, full;
    logic        push, pop;

    logic [15:0] pix;
    logic [8:0]  x, y;
    logic        allowed;
    logic        cmd_fire;
    logic        strobe, strobe_hi, adv;

    // ---------------- FIFO ----------------
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign fill     = wr_ptr - rd_ptr;
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (fill == (AW+1)'(FIFO_DEPTH));
    assign px_ready = !full;
    assign push     = px_valid && px_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= px_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // ---------------- handshake / status ----------------
    assign cmd_ready = empty && (state == S_IDLE);
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign busy      = !empty || (state != S_IDLE);

    // video_fetch is sampled on the same edge that would register the strobe.
    assign allowed   = !(BLANK_ONLY && video_fetch);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (!empty) state_nx = S_LO;
            S_LO:   if (allowed) state_nx = S_HI;
            S_HI:   if (allowed) state_nx = empty ? S_IDLE : S_LO;
            default: state_nx = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // The next pixel is popped on the same edge as the high-byte strobe so
    // pixels stream at one per two cycles with no bubble.
    always_comb begin
        pop       = 1'b0;
        strobe    = 1'b0;
        strobe_hi = 1'b0;
        adv       = 1'b0;
        case (state)
            S_IDLE: pop = !empty;
            S_LO:   strobe = allowed;
            S_HI: begin
                strobe    = allowed;
                strobe_hi = allowed;
                adv       = allowed;
                pop       = allowed && !empty;
            end
            default: ;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wstb   <= 1'b0;
            waddr  <= '0;
            srpage <= '0;
            wdata  <= '0;
            pix    <= '0;
            x      <= '0;
            y      <= '0;
        end else begin
            wstb <= strobe;
            if (strobe) begin
                waddr  <= {y, x, strobe_hi};
                wdata  <= strobe_hi ? pix[15:8] : pix[7:0];
                srpage <= {3'b000, y[8:4]};
            end
            if (pop) begin
                pix <= mem[rd_ptr[AW-1:0]];
            end
            // A command is only accepted when idle, so it never races an advance.
            if (cmd_fire) begin
                x <= cmd_x;
                y <= cmd_y;
            end else if (adv) begin
                if (x == 9'd511) begin
                    x <= 9'd0;
                    y <= y + 9'd1;
                end else begin
                    x <= x + 9'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fb_writer.sv
module tb_fb_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [8:0]  cmd_x = '0;
    logic [8:0]  cmd_y = '0;
    logic        px_valid = 1'b0;
    logic        px_ready;
    logic [15:0] px_data = '0;
    logic        video_fetch = 1'b0;
    logic        wstb;
    logic [18:0] waddr;
    logic [7:0]  srpage;
    logic [7:0]  wdata;
    logic        busy;

    fb_writer #(.FIFO_DEPTH(16), .BLANK_ONLY(1'b1)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_x(cmd_x), .cmd_y(cmd_y),
        .px_valid(px_valid), .px_ready(px_ready), .px_data(px_data),
        .video_fetch(video_fetch),
        .wstb(wstb), .waddr(waddr), .srpage(srpage), .wdata(wdata), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [18:0] a;
        logic [7:0]  d;
    } wr_t;

    wr_t exp_q[$];
    wr_t e;
    int  total = 0;
    int  bad = 0;
    int  strobe_cnt = 0;
    int  n_acc = 0;
    int  mx = 0, my = 0, lin = 0;
    logic vf_prev = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: every accepted pixel becomes two byte writes at the
    // current raster position, which then steps by one modulo 512*512.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
            mx = 0;
            my = 0;
            vf_prev = 1'b0;
        end else begin
            vf_prev = video_fetch;
            if (cmd_valid && cmd_ready) begin
                mx = int'(cmd_x);
                my = int'(cmd_y);
            end
            if (px_valid && px_ready) begin
                lin = my * 512 + mx;
                exp_q.push_back('{a: 19'(lin * 2),     d: px_data[7:0]});
                exp_q.push_back('{a: 19'(lin * 2 + 1), d: px_data[15:8]});
                lin = (lin + 1) % 262144;
                mx = lin % 512;
                my = lin / 512;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && wstb) begin
            strobe_cnt++;
            if (exp_q.size() == 0) begin
                chk("extra_strobe", 32'(exp_q.size()), 1);
            end else begin
                e = exp_q.pop_front();
                chk("waddr", 32'(waddr), 32'(e.a));
                chk("wdata", 32'(wdata), 32'(e.d));
                chk("srpage", 32'(srpage), {27'd0, e.a[18:14]});
            end
            chk("strobe_in_fetch", 32'(vf_prev), 0);
        end
    end

    task automatic do_cmd(input int cx, input int cy);
        bit ok = 1'b0;
        cmd_x = 9'(cx);
        cmd_y = 9'(cy);
        cmd_valid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(posedge clk);
            if (cmd_ready) ok = 1'b1;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("cmd_accept", 32'(ok), 1);
    endtask

    task automatic push_px(input logic [15:0] d);
        bit ok = 1'b0;
        px_data = d;
        px_valid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(posedge clk);
            if (px_ready) ok = 1'b1;
        end
        @(negedge clk);
        px_valid = 1'b0;
        if (ok) n_acc++;
        chk("px_accept", 32'(ok), 1);
    endtask

    task automatic wait_idle(input int lim);
        for (int i = 0; i < lim && busy; i++) @(negedge clk);
        chk("idle", 32'(busy), 0);
    endtask

    task automatic grab(output logic [18:0] a, output logic [7:0] d, output logic [7:0] p);
        bit got = 1'b0;
        a = '0; d = '0; p = '0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (wstb) begin
                got = 1'b1;
                a = waddr; d = wdata; p = srpage;
            end
        end
        chk("strobe_seen", 32'(got), 1);
    endtask

    task automatic expect_strobe(input string tag, input logic [18:0] ea,
                                 input logic [7:0] ed, input logic [7:0] ep);
        logic [18:0] a;
        logic [7:0]  d, p;
        grab(a, d, p);
        chk({tag, "_addr"}, 32'(a), 32'(ea));
        chk({tag, "_data"}, 32'(d), 32'(ed));
        chk({tag, "_page"}, 32'(p), 32'(ep));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        bit got;
        repeat (3) @(negedge clk);
        chk("rst_wstb", 32'(wstb), 0);
        chk("rst_waddr", 32'(waddr), 0);
        chk("rst_srpage", 32'(srpage), 0);
        chk("rst_wdata", 32'(wdata), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_cmd_ready", 32'(cmd_ready), 1);
        chk("rst_px_ready", 32'(px_ready), 1);
        rst = 1'b0;
        @(negedge clk);

        // basic write and latency: accepted at edge c, strobes after c+2, c+3
        do_cmd(5, 3);
        push_px(16'h7C1F);
        chk("t1_lat0", 32'(wstb), 0);
        @(negedge clk);
        chk("t1_lat1", 32'(wstb), 0);
        @(negedge clk);
        chk("t1_lo_stb", 32'(wstb), 1);
        chk("t1_lo_addr", 32'(waddr), 32'h00C0A);
        chk("t1_lo_data", 32'(wdata), 32'h1F);
        chk("t1_lo_page", 32'(srpage), 0);
        @(negedge clk);
        chk("t1_hi_stb", 32'(wstb), 1);
        chk("t1_hi_addr", 32'(waddr), 32'h00C0B);
        chk("t1_hi_data", 32'(wdata), 32'h7C);
        @(negedge clk);
        chk("t1_after", 32'(wstb), 0);
        chk("t1_busy", 32'(busy), 0);

        // X wrap into next row
        do_cmd(511, 2);
        push_px(16'h1234);
        push_px(16'h5678);
        expect_strobe("t2a_lo", 19'h00BFE, 8'h34, 8'h00);
        expect_strobe("t2a_hi", 19'h00BFF, 8'h12, 8'h00);
        expect_strobe("t2b_lo", 19'h00C00, 8'h78, 8'h00);
        expect_strobe("t2b_hi", 19'h00C01, 8'h56, 8'h00);
        wait_idle(50);

        // full-frame wrap
        do_cmd(511, 511);
        push_px(16'hABCD);
        push_px(16'h0F0E);
        expect_strobe("t3a_lo", 19'h7FFFE, 8'hCD, 8'h1F);
        expect_strobe("t3a_hi", 19'h7FFFF, 8'hAB, 8'h1F);
        expect_strobe("t3b_lo", 19'h00000, 8'h0E, 8'h00);
        expect_strobe("t3b_hi", 19'h00001, 8'h0F, 8'h00);
        wait_idle(50);

        // fetch hold with a full FIFO, then a back-to-back drain
        do_cmd(0, 100);
        video_fetch = 1'b1;
        n_acc = 0;
        s0 = strobe_cnt;
        for (int i = 0; i < 17; i++) push_px(16'($urandom));
        repeat (3) @(negedge clk);
        chk("t4_accepted", 32'(n_acc), 17);
        chk("t4_no_strobe", 32'(strobe_cnt - s0), 0);
        chk("t4_px_ready", 32'(px_ready), 0);
        chk("t4_busy", 32'(busy), 1);
        video_fetch = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (wstb) got = 1'b1;
        end
        chk("t4_first", 32'(got), 1);
        for (int i = 0; i < 2 * 17; i++) begin
            chk("t4_b2b", 32'(wstb), 1);
            chk("t4_busy_fall", 32'(busy), (i == 2 * 17 - 1) ? 0 : 1);
            @(negedge clk);
        end
        chk("t4_end", 32'(wstb), 0);

        // fetch window splitting a pixel between its two bytes
        do_cmd(10, 20);
        push_px(16'h1234);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (wstb) got = 1'b1;
        end
        chk("t5_lo_seen", 32'(got), 1);
        chk("t5_lo_addr", 32'(waddr), 32'h05014);
        video_fetch = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t5_hi_held", 32'(wstb), 0);
        end
        video_fetch = 1'b0;
        @(negedge clk);
        chk("t5_hi_stb", 32'(wstb), 1);
        chk("t5_hi_addr", 32'(waddr), 32'h05015);
        chk("t5_hi_data", 32'(wdata), 32'h12);
        wait_idle(20);

        // reset between the two bytes of a pixel with three more buffered
        video_fetch = 1'b1;
        do_cmd(7, 7);
        for (int i = 0; i < 4; i++) push_px(16'($urandom));
        video_fetch = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (wstb) got = 1'b1;
        end
        chk("t6_lo_seen", 32'(got), 1);
        #2 rst = 1'b1;
        #1;
        chk("t6_wstb", 32'(wstb), 0);
        chk("t6_waddr", 32'(waddr), 0);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_cmd_ready", 32'(cmd_ready), 1);
        chk("t6_px_ready", 32'(px_ready), 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        s0 = strobe_cnt;
        repeat (20) @(negedge clk);
        chk("t6_no_strobe", 32'(strobe_cnt - s0), 0);
        chk("t6_busy_after", 32'(busy), 0);

        // randomized traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            cmd_valid   = ($urandom_range(0, 7) == 0);
            cmd_x       = 9'($urandom);
            cmd_y       = 9'($urandom);
            px_valid    = $urandom_range(0, 1) == 1;
            px_data     = 16'($urandom);
            video_fetch = ($urandom_range(0, 3) == 0);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        px_valid = 1'b0;
        video_fetch = 1'b0;
        wait_idle(200);
        @(negedge clk);
        chk("drain_queue", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
